// File: rtl/dual_rail_tp_tx_ctrl.sv
// dual_rail_tp_tx_ctrl
//   Drives a WIDTH-bit dual-rail, two-phase (transition-signalled) link from
//   a clocked valid/ready producer. For each accepted word, bit i toggles its
//   true rail out[i][1] when the bit is 1, or its false rail out[i][0] when
//   the bit is 0. The controller then waits for the receiver's toggle-ack.
//   The ack arrives asynchronously and is synchronised here. Only after that
//   ack does the controller accept the next word.
//
// Optional feature (compile-time macro): DUAL_RAIL_TX_ACK_TIMEOUT_EN
//   When defined, a 16-bit wait counter runs while a word is in flight.
//   When it reaches TIMEOUT, the sticky timeout_err flag is set. A late ack
//   still completes the word. When the macro is undefined, timeout_err is
//   tied to 0.
//
// Parameters
//   WIDTH        data bits (link is WIDTH x 2 rails)
//   SYNC_STAGES  ack synchroniser depth, 2..4
//   TIMEOUT      WAIT_ACK cycles before timeout_err, 1..65535
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      word to send, sampled when in_valid & in_ready
//   in_valid     producer has a word
//   in_ready     controller can accept a word (combinational)
//   out          dual-rail link, [i][1]=true rail, [i][0]=false rail
//   ack_in       receiver toggle-ack, asynchronous to clk
//   busy         word in flight
//   tx_count     completed words, wraps modulo 2^16
//   proto_err    sticky: ack toggle seen while idle
//   timeout_err  sticky: ack overdue (feature macro only)
//   err_clr      synchronous clear of both error flags
module dual_rail_tp_tx_ctrl #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0][1:0] out,
  input  logic                  ack_in,
  output logic                  busy,
  output logic [15:0]           tx_count,
  output logic                  proto_err,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  // Elaboration-time parameter range checks.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be 1..65535");
  end

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

  state_t                  state_reg;
  logic [SYNC_STAGES-1:0]  sync_reg;
  logic                    ack_last_reg;
  logic [WIDTH-1:0][1:0]   rail_reg;
  logic [WIDTH-1:0][1:0]   toggle_mask;
  logic                    busy_reg;
  logic [15:0]             tx_count_reg;
  logic [15:0]             tx_count_next;
  logic                    proto_err_reg;

  logic                    ack_s;
  logic                    ack_evt;
  logic                    accept;
  logic                    idle_evt;
  logic                    done_evt;

  // Each bit flips exactly one of its two rails, selected by the data value.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign toggle_mask[gi] = in_data[gi] ? 2'b10 : 2'b01;
  end

  assign ack_s    = sync_reg[SYNC_STAGES-1];
  assign ack_evt  = ack_s ^ ack_last_reg;
  // Gated with rst_n so that nothing is offered to the producer while the
  // controller is held in reset.
  assign in_ready = (state_reg == IDLE) & rst_n;
  assign accept   = in_valid & in_ready;
  assign idle_evt = (state_reg == IDLE) & ack_evt;
  assign done_evt = (state_reg == WAIT_ACK) & ack_evt;

  // The counter register is rewritten every cycle from its own value. This
  // keeps the path simple: one adder and one enable.
  always_comb begin
    tx_count_next = tx_count_reg;
    if (done_evt) begin
      tx_count_next = tx_count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sync_reg      <= '0;
      ack_last_reg  <= 1'b0;
      rail_reg      <= '0;
      busy_reg      <= 1'b0;
      tx_count_reg  <= 16'd0;
      proto_err_reg <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[SYNC_STAGES-2:0], ack_in};
      tx_count_reg  <= tx_count_next;
      // A new error takes priority over a clear in the same cycle.
      proto_err_reg <= idle_evt | (proto_err_reg & ~err_clr);

      // Each ack toggle is consumed exactly once, whichever state sees it.
      if (ack_evt) begin
        ack_last_reg <= ack_s;
      end

      case (state_reg)
        IDLE: begin
          // An unexpected toggle in IDLE does not block a simultaneous
          // acceptance; the word still goes out.
          if (accept) begin
            rail_reg  <= rail_reg ^ toggle_mask;
            busy_reg  <= 1'b1;
            state_reg <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_evt) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef DUAL_RAIL_TX_ACK_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

  logic [15:0] wait_cnt_reg;
  logic        timeout_err_reg;
  logic        timeout_set;

  // Fires on the TIMEOUT-th clock edge spent waiting. The counter holds the
  // number of WAIT_ACK edges already seen.
  assign timeout_set = (state_reg == WAIT_ACK) & ~ack_evt &
                       ((wait_cnt_reg + 16'd1) == TIMEOUT_L);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg    <= 16'd0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= timeout_set | (timeout_err_reg & ~err_clr);
      if (accept) begin
        wait_cnt_reg <= 16'd0;
      end else if (state_reg == WAIT_ACK && !ack_evt && wait_cnt_reg != 16'hFFFF) begin
        wait_cnt_reg <= wait_cnt_reg + 16'd1;
      end
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  assign out       = rail_reg;
  assign busy      = busy_reg;
  assign tx_count  = tx_count_reg;
  assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_dual_rail_tp_tx_ctrl.sv
// Directed bench for dual_rail_tp_tx_ctrl (WIDTH=4, SYNC_STAGES=2, TIMEOUT=10).
module tb_dual_rail_tp_tx_ctrl;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int TO = 10;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0][1:0] out;
  logic            ack_in;
  logic            busy;
  logic [15:0]     tx_count;
  logic            proto_err;
  logic            timeout_err;
  logic            err_clr;

  int checks = 0;
  int errors = 0;

  dual_rail_tp_tx_ctrl #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .TIMEOUT     (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out         (out),
    .ack_in      (ack_in),
    .busy        (busy),
    .tx_count    (tx_count),
    .proto_err   (proto_err),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic [7:0]   exp_out;
    logic [15:0]  exp_cnt;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one word, then return the ack by hand. This checks the handshake
  // latency edge by edge.
  task automatic send_manual(input logic [W-1:0] d, input logic [7:0] exp_out,
                             input logic [15:0] exp_cnt);
    check("ready_before", 32'(in_ready), 32'd1);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("out_after_accept", 32'(out), 32'(exp_out));
    check("busy_after_accept", 32'(busy), 32'd1);
    check("ready_in_flight", 32'(in_ready), 32'd0);
    ack_in = ~ack_in;
    repeat (S) tick();
    check("ready_not_early", 32'(in_ready), 32'd0);
    tick();
    check("ready_after_ack", 32'(in_ready), 32'd1);
    check("tx_count", 32'(tx_count), 32'(exp_cnt));
    check("busy_done", 32'(busy), 32'd0);
    $display("word data=%b out=0x%02h tx_count=%0d", d, out, tx_count);
  endtask

  initial begin
    int acc;
    int last;
    int bad_gap;
    int cyc;
    logic [7:0] prev_out;

    // Out rails packed as {b3t,b3f,b2t,b2f,b1t,b1f,b0t,b0f}.
    vecs[0] = '{4'b1010, 8'h99, 16'd1};
    vecs[1] = '{4'b1010, 8'h00, 16'd2};
    vecs[2] = '{4'b1111, 8'hAA, 16'd3};
    vecs[3] = '{4'b0000, 8'hFF, 16'd4};
    vecs[4] = '{4'b0110, 8'h96, 16'd5};
    vecs[5] = '{4'b0001, 8'hC0, 16'd6};

    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    ack_in   = 1'b0;
    err_clr  = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_out", 32'(out), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(tx_count), 32'd0);
    check("rst_errs", 32'({proto_err, timeout_err}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", 32'(in_ready), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      send_manual(vecs[i].data, vecs[i].exp_out, vecs[i].exp_cnt);
    end

    // Ack toggle while idle. err_clr is held across the event, so the new
    // error must win on that edge and then clear on the next one.
    ack_in  = ~ack_in;
    err_clr = 1'b1;
    repeat (S + 1) tick();
    check("proto_err_set", 32'(proto_err), 32'd1);
    check("proto_count_same", 32'(tx_count), 32'd6);
    check("proto_still_ready", 32'(in_ready), 32'd1);
    tick();
    check("proto_err_clr", 32'(proto_err), 32'd0);
    err_clr = 1'b0;
    $display("proto ack toggle in idle handled, proto_err=%0d", proto_err);

    // Back-to-back 16 words against a zero-delay receiver.
    acc = 0; last = 0; bad_gap = 0; cyc = 0;
    prev_out = out;
    in_valid = 1'b1;
    while ((acc < 16 || !in_ready) && cyc < 400) begin
      if (in_ready && acc < 16) begin
        if (acc > 0 && cyc - last != S + 2) bad_gap++;
        last = cyc;
        in_data = acc[3:0];
        acc++;
      end
      tick();
      if (acc == 16) in_valid = 1'b0;
      if (out != prev_out) begin
        ack_in = ~ack_in;
        prev_out = out;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_not_timed_out", 32'(cyc < 400), 32'd1);
    check("b2b_accepts", 32'(acc), 32'd16);
    check("b2b_gap_errors", 32'(bad_gap), 32'd0);
    check("b2b_count", 32'(tx_count), 32'd22);
    check("b2b_errs", 32'({proto_err, timeout_err}), 32'd0);
    $display("burst 16 words in %0d cycles, tx_count=%0d", cyc, tx_count);

    // Reset while a word is in flight.
    in_data  = 4'b0110;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("midword_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midword_rst_out", 32'(out), 32'd0);
    check("midword_rst_count", 32'(tx_count), 32'd0);
    check("midword_rst_busy", 32'(busy), 32'd0);
    ack_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset mid-word, out=0x%02h tx_count=%0d", out, tx_count);

`ifdef DUAL_RAIL_TX_ACK_TIMEOUT_EN
    in_data  = 4'b1010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("to_out", 32'(out), 32'h99);
    repeat (TO - 1) tick();
    check("to_not_early", 32'(timeout_err), 32'd0);
    tick();
    check("to_set", 32'(timeout_err), 32'd1);
    check("to_still_busy", 32'(busy), 32'd1);
    ack_in = ~ack_in;
    repeat (S + 1) tick();
    check("to_late_ack_ready", 32'(in_ready), 32'd1);
    check("to_late_ack_count", 32'(tx_count), 32'd1);
    check("to_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_clr", 32'(timeout_err), 32'd0);
    $display("timeout word done, tx_count=%0d", tx_count);
`else
    send_manual(4'b1010, 8'h99, 16'd1);
    check("timeout_tied_low", 32'(timeout_err), 32'd0);
`endif

    // Wrap: preset the counter to 0xFFFF; one more word must wrap it to 0.
    force dut.tx_count_reg = 16'hFFFF;
    tick();
    release dut.tx_count_reg;
    tick();
    check("preset_count", 32'(tx_count), 32'hFFFF);
    send_manual(4'b1010, 8'h00, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
